// File: rtl/direction_accumulator.sv
// Purpose: accumulates mic-energy-weighted location vectors over 2^WINDOW_LOG2 sample sets and emits the averaged direction.
// Latency: vector_valid_out pulses NUM_MICS+1 cycles after the final transfer of a window; one sample set per NUM_MICS+1 cycles.
// Backpressure: sample_ready_out is high only in IDLE; samples offered while not ready are ignored, never buffered.
module direction_accumulator #(
    parameter int NUM_MICS     = 3,
    parameter int SAMPLE_WIDTH = 32,
    parameter int COORD_WIDTH  = 16,
    parameter int WINDOW_LOG2  = 10
) (
    input  logic                                       clk_in,
    input  logic                                       rst_in_n,
    input  logic                                       sample_valid_in,
    output logic                                       sample_ready_out,
    input  logic [SAMPLE_WIDTH-1:0]                    central_mic,
    input  logic [NUM_MICS-1:0][SAMPLE_WIDTH-1:0]      peripheral_mics,
    // mic_locations[i][0] is x, mic_locations[i][1] is y
    input  logic [NUM_MICS-1:0][1:0][COORD_WIDTH-1:0]  mic_locations,
    input  logic                                       clear_in,
    output logic [2*COORD_WIDTH-1:0]                   vector_out,
    output logic                                       vector_valid_out
);

    localparam int ACC_W  = 2*COORD_WIDTH + 2 + $clog2(NUM_MICS) + WINDOW_LOG2;
    localparam int PROD_W = 2*COORD_WIDTH + 1;
    localparam int SHIFT  = COORD_WIDTH + WINDOW_LOG2;
    localparam int IDX_W  = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1;
    localparam int CNT_W  = (WINDOW_LOG2 > 0) ? WINDOW_LOG2 : 1;

    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_MICS - 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(2**WINDOW_LOG2 - 1);
    localparam logic signed [ACC_W-1:0] VMAX     = {{(ACC_W-COORD_WIDTH+1){1'b0}}, {(COORD_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] VMIN     = ~VMAX;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                                state_q, state_d;
    logic [IDX_W-1:0]                      idx_q;
    logic [CNT_W-1:0]                      cnt_q;
    logic signed [ACC_W-1:0]               acc_x_q, acc_y_q;
    logic [SAMPLE_WIDTH-1:0]               central_q;
    logic [NUM_MICS-1:0][SAMPLE_WIDTH-1:0] peripheral_q;

    logic                                  xfer;
    logic                                  last_mic;
    logic                                  win_full;
    logic [COORD_WIDTH-1:0]                mag_c, mag_p;
    logic signed [COORD_WIDTH:0]           weight;
    logic signed [COORD_WIDTH-1:0]         loc_x, loc_y;
    logic signed [PROD_W-1:0]              prod_x, prod_y;

    // |s| with the most negative code pinned to max positive, then the top COORD_WIDTH magnitude bits
    function automatic logic [COORD_WIDTH-1:0] mag(input logic [SAMPLE_WIDTH-1:0] s);
        logic [SAMPLE_WIDTH-1:0] a;
        if (s == {1'b1, {(SAMPLE_WIDTH-1){1'b0}}})
            a = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
        else if (s[SAMPLE_WIDTH-1])
            a = -s;
        else
            a = s;
        return a[SAMPLE_WIDTH-2 -: COORD_WIDTH];
    endfunction

    // window average: arithmetic shift then clamp into the signed output component range
    function automatic logic [COORD_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (s > VMAX)
            return VMAX[COORD_WIDTH-1:0];
        else if (s < VMIN)
            return VMIN[COORD_WIDTH-1:0];
        else
            return s[COORD_WIDTH-1:0];
    endfunction

    // per-mic weight and weighted location terms for the mic selected this cycle
    always_comb begin
        mag_c  = mag(central_q);
        mag_p  = mag(peripheral_q[idx_q]);
        weight = $signed({1'b0, mag_p}) - $signed({1'b0, mag_c});
        loc_x  = $signed(mic_locations[idx_q][0]);
        loc_y  = $signed(mic_locations[idx_q][1]);
        prod_x = PROD_W'(weight) * PROD_W'(loc_x);
        prod_y = PROD_W'(weight) * PROD_W'(loc_y);
    end

    // state register
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // next-state and handshake; clear overrides any transition
    always_comb begin
        state_d          = state_q;
        sample_ready_out = (state_q == IDLE);
        xfer             = sample_valid_in && (state_q == IDLE) && !clear_in;
        last_mic         = (idx_q == IDX_LAST);
        win_full         = (cnt_q == CNT_LAST);
        case (state_q)
            IDLE:    if (xfer) state_d = MAC;
            MAC:     if (last_mic) state_d = win_full ? DONE : IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_in)
            state_d = IDLE;
    end

    // datapath: sample capture, MAC, window counter and result register
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            idx_q            <= '0;
            cnt_q            <= '0;
            acc_x_q          <= '0;
            acc_y_q          <= '0;
            central_q        <= '0;
            peripheral_q     <= '0;
            vector_out       <= '0;
            vector_valid_out <= 1'b0;
        end else if (clear_in) begin
            idx_q            <= '0;
            cnt_q            <= '0;
            acc_x_q          <= '0;
            acc_y_q          <= '0;
            vector_valid_out <= 1'b0;
        end else begin
            vector_valid_out <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        central_q    <= central_mic;
                        peripheral_q <= peripheral_mics;
                        idx_q        <= '0;
                    end
                end
                MAC: begin
                    acc_x_q <= acc_x_q + ACC_W'(prod_x);
                    acc_y_q <= acc_y_q + ACC_W'(prod_y);
                    if (last_mic) begin
                        idx_q <= '0;
                        if (!win_full)
                            cnt_q <= cnt_q + 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    vector_out       <= {sat(acc_x_q), sat(acc_y_q)};
                    vector_valid_out <= 1'b1;
                    acc_x_q          <= '0;
                    acc_y_q          <= '0;
                    cnt_q            <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_direction_accumulator.sv
// Purpose: directed self-checking bench for direction_accumulator (3 mics, 4-sample window).
// Latency: checks the NUM_MICS+1 cycle result latency and NUM_MICS+1 cycle transfer spacing.
// Backpressure: holds sample_valid_in high to observe sample_ready_out gating.
module tb_direction_accumulator;

    localparam int NM = 3;
    localparam int SW = 32;
    localparam int CW = 16;
    localparam int WL = 2;

    logic                        clk_in = 1'b0;
    logic                        rst_in_n;
    logic                        sample_valid_in;
    logic                        sample_ready_out;
    logic [SW-1:0]               central_mic;
    logic [NM-1:0][SW-1:0]       peripheral_mics;
    logic [NM-1:0][1:0][CW-1:0]  mic_locations;
    logic                        clear_in;
    logic [2*CW-1:0]             vector_out;
    logic                        vector_valid_out;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int pulse_cyc = 0;
    int tx_cyc = 0;

    localparam logic [31:0] STRONG    = 32'h4000_0000;
    localparam logic [31:0] EXP_BASIC = {16'd500, 16'd0};

    direction_accumulator #(
        .NUM_MICS(NM), .SAMPLE_WIDTH(SW), .COORD_WIDTH(CW), .WINDOW_LOG2(WL)
    ) dut (
        .clk_in(clk_in),
        .rst_in_n(rst_in_n),
        .sample_valid_in(sample_valid_in),
        .sample_ready_out(sample_ready_out),
        .central_mic(central_mic),
        .peripheral_mics(peripheral_mics),
        .mic_locations(mic_locations),
        .clear_in(clear_in),
        .vector_out(vector_out),
        .vector_valid_out(vector_valid_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (vector_valid_out) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_locs_default();
        mic_locations[0][0] = 16'd1000;  mic_locations[0][1] = 16'd0;
        mic_locations[1][0] = 16'd0;     mic_locations[1][1] = 16'd1000;
        mic_locations[2][0] = 16'hFC18;  mic_locations[2][1] = 16'hFC18;
    endtask

    task automatic xfer(input logic [31:0] c, input logic [31:0] p0,
                        input logic [31:0] p1, input logic [31:0] p2);
        int w = 0;
        while (!sample_ready_out && w < 50) begin
            @(posedge clk_in); #1;
            w++;
        end
        check("xfer_ready", {63'd0, sample_ready_out}, 64'd1);
        central_mic        = c;
        peripheral_mics[0] = p0;
        peripheral_mics[1] = p1;
        peripheral_mics[2] = p2;
        sample_valid_in    = 1'b1;
        @(posedge clk_in); #1;
        sample_valid_in    = 1'b0;
        tx_cyc             = cyc;
    endtask

    task automatic expect_pulse(input string tag, input logic [31:0] exp);
        int p0 = pulse_cnt;
        int w  = 0;
        while (pulse_cnt == p0 && w < 20) begin
            @(negedge clk_in);
            w++;
        end
        repeat (3) @(negedge clk_in);
        check({tag, "_count"}, 64'(pulse_cnt - p0), 64'd1);
        check({tag, "_latency"}, 64'(pulse_cyc - tx_cyc), 64'd4);
        check({tag, "_vector"}, {32'd0, vector_out}, {32'd0, exp});
        @(posedge clk_in); #1;
    endtask

    initial begin
        int tx[8];
        int ntx;
        int p_start;

        rst_in_n        = 1'b0;
        sample_valid_in = 1'b0;
        clear_in        = 1'b0;
        central_mic     = '0;
        peripheral_mics = '0;
        set_locs_default();

        // reset state, during and after reset
        #12;
        check("rst_ready", {63'd0, sample_ready_out}, 64'd1);
        check("rst_vector", {32'd0, vector_out}, 64'd0);
        check("rst_valid", {63'd0, vector_valid_out}, 64'd0);
        #11 rst_in_n = 1'b1;
        @(posedge clk_in); #1;
        check("post_rst_ready", {63'd0, sample_ready_out}, 64'd1);
        check("post_rst_vector", {32'd0, vector_out}, 64'd0);
        check("post_rst_valid", {63'd0, vector_valid_out}, 64'd0);

        // basic window: mic0 strong -> x = 4*32768*1000 >> 18 = 500
        repeat (4) xfer(32'd0, STRONG, 32'd0, 32'd0);
        expect_pulse("basic", EXP_BASIC);
        repeat (5) @(posedge clk_in);
        #1 check("basic_hold", {32'd0, vector_out}, {32'd0, EXP_BASIC});

        // handshake: valid held high for two windows
        p_start = pulse_cnt;
        ntx = 0;
        central_mic        = 32'd0;
        peripheral_mics[0] = STRONG;
        peripheral_mics[1] = 32'd0;
        peripheral_mics[2] = 32'd0;
        sample_valid_in    = 1'b1;
        for (int c = 0; c < 100 && ntx < 8; c++) begin
            if (sample_ready_out) begin
                tx[ntx] = c;
                ntx++;
            end
            @(posedge clk_in); #1;
        end
        sample_valid_in = 1'b0;
        repeat (8) @(posedge clk_in);
        #1;
        check("hs_ntx", 64'(ntx), 64'd8);
        for (int k = 1; k < 8; k++)
            check($sformatf("hs_gap%0d", k), 64'(tx[k] - tx[k-1]), (k == 4) ? 64'd5 : 64'd4);
        check("hs_pulses", 64'(pulse_cnt - p_start), 64'd2);
        check("hs_vector", {32'd0, vector_out}, {32'd0, EXP_BASIC});

        // positive saturation
        for (int i = 0; i < NM; i++) begin
            mic_locations[i][0] = 16'h7FFF;
            mic_locations[i][1] = 16'h7FFF;
        end
        repeat (4) xfer(32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        expect_pulse("sat_pos", 32'h7FFF_7FFF);

        // negative saturation
        repeat (4) xfer(32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0);
        expect_pulse("sat_neg", 32'h8000_8000);
        set_locs_default();

        // clear mid-window: two mic1 samples discarded, then a fresh basic window
        p_start = pulse_cnt;
        repeat (2) xfer(32'd0, 32'd0, STRONG, 32'd0);
        clear_in = 1'b1;
        @(posedge clk_in); #1;
        clear_in = 1'b0;
        check("clr_ready", {63'd0, sample_ready_out}, 64'd1);
        repeat (4) xfer(32'd0, STRONG, 32'd0, 32'd0);
        check("clr_no_early_pulse", 64'(pulse_cnt - p_start), 64'd0);
        expect_pulse("clr", EXP_BASIC);

        // clear coincident with a transfer: the sample is dropped
        p_start = pulse_cnt;
        central_mic        = 32'd0;
        peripheral_mics[0] = 32'd0;
        peripheral_mics[1] = STRONG;
        peripheral_mics[2] = 32'd0;
        sample_valid_in    = 1'b1;
        clear_in           = 1'b1;
        @(posedge clk_in); #1;
        sample_valid_in    = 1'b0;
        clear_in           = 1'b0;
        check("coinc_ready", {63'd0, sample_ready_out}, 64'd1);
        repeat (4) xfer(32'd0, STRONG, 32'd0, 32'd0);
        check("coinc_no_early_pulse", 64'(pulse_cnt - p_start), 64'd0);
        expect_pulse("coinc", EXP_BASIC);

        // asynchronous reset mid-MAC
        xfer(32'd0, 32'd0, STRONG, 32'd0);
        #3 rst_in_n = 1'b0;
        #1;
        check("arst_vector", {32'd0, vector_out}, 64'd0);
        check("arst_valid", {63'd0, vector_valid_out}, 64'd0);
        check("arst_ready", {63'd0, sample_ready_out}, 64'd1);
        @(negedge clk_in); #2;
        rst_in_n = 1'b1;
        @(posedge clk_in); #1;
        p_start = pulse_cnt;
        repeat (4) xfer(32'd0, STRONG, 32'd0, 32'd0);
        check("arst_no_early_pulse", 64'(pulse_cnt - p_start), 64'd0);
        expect_pulse("arst", EXP_BASIC);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
